rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
Arbitrates one synchronous-read ROM port (registered output, 1-cycle read latency, e.g. a 4x4 ROM) between NREQ requesters. A small FSM runs one read at a time: it picks a winner, presents the address, waits for the ROM's registered data, then returns a tagged response. It sits between the requesting blocks and the ROM instance, and is the only driver of the ROM address.

Parameters:
NREQ, 4, number of requesters (>=2)
AW, 2, ROM address width
DW, 4, ROM data width
IDW, $clog2(NREQ), requester-ID width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level
req_addr  input  NREQ*AW  packed addresses; slice i = req_addr[i*AW +: AW]
gnt  output  NREQ  one-hot grant pulse, registered
rom_addr  output  AW  address to ROM, registered
rom_data  input  DW  ROM registered data_out
rsp_valid  output  1  response strobe, registered
rsp_id  output  IDW  requester index of response
rsp_data  output  DW  read data
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate on rst high): state=IDLE; gnt=0, rom_addr=0, rsp_valid=0, rsp_id=0, busy=0; priority pointer=0.
- States: IDLE, ISSUE, RESP.
- IDLE: if req==0, stay. Otherwise arbitrate; at the clock edge, latch the winner's address into rom_addr, set gnt to the winner's one-hot, latch the winner index, and go to ISSUE.
- ISSUE (1 cycle): gnt is high for this cycle only; rom_addr is stable, and the ROM captures mem[rom_addr] at the end of the cycle. Next state is RESP, with gnt cleared.
- RESP (1 cycle): rsp_valid=1, rsp_id=latched index, rsp_data=rom_data. Outside RESP, rsp_data=0 and rsp_valid=0.
- RESP exit: if any req is high, arbitrate and go directly to ISSUE (back-to-back, same actions as in IDLE). Otherwise go to IDLE.
- Throughput: 1 read per 2 cycles. Latency: req sampled at edge N, gnt high in cycle N+1, rsp_valid high in cycle N+2.
- Handshake, requester side:
  - Hold req and its address slice until gnt is seen.
  - Address is captured at the grant edge, so it may change from the gnt cycle onward.
  - Drop req at the edge ending the gnt cycle for a single read. Holding req high requests another read.
  - Withdrawing req before grant is legal and has no effect.
- rom_addr holds its last value in IDLE and RESP when no new grant is made.
- Simultaneous requests: exactly one grant per ISSUE; losers stay pending with no loss.
- Reset mid-operation: any in-flight read is dropped with no response. Outputs go to reset values asynchronously. After rst deasserts, the block resumes from IDLE.
- The ROM's own reset is not driven by this block. Integration ties it to the same rst; an in-progress sync reset of the ROM is covered by the dropped read.

Optional Feature:
ROM_ARB_RR_EN
- Defined (round-robin): the search starts at the priority pointer and wraps modulo NREQ. After each grant, pointer = (winner+1) mod NREQ.
- Undefined (fixed priority): the lowest index wins, and the pointer logic is absent.
- Both builds keep identical ports, FSM and timing.

Test Plan:
- ROM loaded with mem[0..3] = 0001, 0010, 1010, 1111. Single req[2]=1 with addr 2'b10, dropped after gnt -> gnt=0100 in cycle N+1; rsp_valid=1, rsp_id=2, rsp_data=1010 in N+2; then IDLE, busy=0.
- All four req held high with addr = index, RR build -> grants 0,1,2,3,0 every 2 cycles with no IDLE gap; responses 0001, 0010, 1010, 1111 with matching rsp_id.
- Same stimulus, fixed-priority build -> every grant goes to requester 0 and rsp_data is always 0001. Dropping req[0] -> requester 1 is granted next.
- rst pulsed for 1 cycle during ISSUE -> gnt and busy go to 0 immediately, no rsp_valid for that read. After release, pending req[1] is granted 1 cycle after sampling and the pointer restarts at 0.
- req[3] asserted and withdrawn before any edge samples it; req=0 for 10 cycles -> no gnt, no rsp_valid, rom_addr unchanged.
- Requester 1 changes req_addr from 2'b01 to 2'b11 in its gnt cycle -> response data is 0010 (the captured address), not 1111.

Source files
------------

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares one synchronous-read ROM port (registered data_out, 1-cycle read
// latency) between NREQ requesters. One read is in flight at a time:
//   IDLE  -> pick a winner, latch its address, pulse its grant -> ISSUE
//   ISSUE -> ROM samples rom_addr at the end of this cycle     -> RESP
//   RESP  -> return rom_data tagged with the winner index; if any request is
//            pending, arbitrate again and go straight to ISSUE, else IDLE.
// A new read can therefore start every 2 cycles.
//
// Build option:
//   ROM_ARB_RR_EN defined   : round-robin arbitration. The search starts at a
//                             priority pointer and the pointer moves to
//                             winner+1 after each grant.
//   ROM_ARB_RR_EN undefined : fixed priority, lowest index wins, no pointer.
//   Ports, FSM and timing are identical in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester request level
//   req_addr   packed request addresses, slice i = req_addr[i*AW +: AW]
//   gnt        one-hot grant pulse (registered, high during ISSUE only)
//   rom_addr   ROM address (registered, holds when no new grant is made)
//   rom_data   ROM registered read data
//   rsp_valid  response strobe (registered, high during RESP only)
//   rsp_id     requester index of the response
//   rsp_data   read data during RESP, zero otherwise
//   busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter  int NREQ = 4,
    parameter  int AW   = 2,
    parameter  int DW   = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_data,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [AW-1:0]   rom_addr_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  id_q;
    logic            busy_q;

    // Arbitration result for the current request vector.
    logic            any_req_d;
    logic [IDW-1:0]  win_d;
    logic [NREQ-1:0] win_onehot_d;
    logic [AW-1:0]   win_addr_d;

`ifdef ROM_ARB_RR_EN
    logic [IDW-1:0] ptr_q;
    logic           found_d;
    int             idx_d;

    // Scan NREQ positions starting at the pointer, wrapping modulo NREQ;
    // the first requester found wins.
    always_comb begin
        win_d   = '0;
        found_d = 1'b0;
        idx_d   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_d = int'(ptr_q) + i;
            if (idx_d >= NREQ) begin
                idx_d = idx_d - NREQ;
            end
            if (!found_d && req[idx_d]) begin
                win_d   = IDW'(idx_d);
                found_d = 1'b1;
            end
        end
    end
`else
    // Scan from the top down so the lowest pending index is assigned last.
    always_comb begin
        win_d = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_d = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        any_req_d           = |req;
        win_onehot_d        = '0;
        win_onehot_d[win_d] = 1'b1;
        win_addr_d          = req_addr[int'(win_d)*AW +: AW];
    end

    // Main FSM. All outputs are registered alongside the state so that each
    // output changes exactly on the edge that enters or leaves its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rom_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            id_q        <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and RESP share the "start a new read" decision; this is
                // what gives back-to-back reads with no IDLE gap.
                IDLE, RESP: begin
                    rsp_valid_q <= 1'b0;
                    if (any_req_d) begin
                        state_q    <= ISSUE;
                        gnt_q      <= win_onehot_d;
                        rom_addr_q <= win_addr_d;
                        id_q       <= win_d;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_q     <= RESP;
                    gnt_q       <= '0;
                    rsp_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROM_ARB_RR_EN
    // Pointer advances past the winner on every grant, from IDLE or RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if ((state_q == IDLE || state_q == RESP) && any_req_d) begin
            if (win_d == IDW'(NREQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= win_d + 1'b1;
            end
        end
    end
`endif

    assign gnt       = gnt_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;
    // The ROM output is only meaningful in RESP; force zero elsewhere so
    // downstream logic never sees stale data.
    assign rsp_data  = rsp_valid_q ? rom_data : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] req_addr;
    logic [3:0] gnt;
    logic [1:0] rom_addr;
    logic [3:0] rom_data;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [3:0] rsp_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // ROM model: mem[0..3] = 0001, 0010, 1010, 1111, registered read.
    logic [3:0] rom_mem [0:3];
    initial begin
        rom_mem[0] = 4'b0001;
        rom_mem[1] = 4'b0010;
        rom_mem[2] = 4'b1010;
        rom_mem[3] = 4'b1111;
    end
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    rom_arbiter #(.NREQ(4), .AW(2), .DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; observe 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_addr = '0;
        step(); step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (rom_addr !== 2'b00) begin errors++; $display("FAIL reset_rom_addr: got %b expected 00", rom_addr); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_data !== 4'b0000) begin errors++; $display("FAIL reset_rsp_data: got %b expected 0000", rsp_data); end
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_read();
        req = 4'b0100; req_addr = 8'b00_10_00_00;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
        checks++; if (rom_addr !== 2'b10) begin errors++; $display("FAIL single_rom_addr: got %b expected 10", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_issue: got %b expected 1", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_no_early_rsp: got %b expected 0", rsp_valid); end
        req = 4'b0000;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_clear: got %b expected 0000", gnt); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d expected 2", rsp_id); end
        checks++; if (rsp_data !== 4'b1010) begin errors++; $display("FAIL single_rsp_data: got %b expected 1010", rsp_data); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_valid_idle: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 4'b0000) begin errors++; $display("FAIL single_rsp_data_idle: got %b expected 0000", rsp_data); end
        checks++; if (rom_addr !== 2'b10) begin errors++; $display("FAIL single_rom_addr_hold: got %b expected 10", rom_addr); end
    endtask

    // All four requesting with addr = index. RR order 0,1,2,3,0; fixed always 0.
    task automatic test_back_to_back();
        int         w;
        logic [3:0] exp_gnt;
        logic [3:0] exp_data;
        rst = 1'b1; #2; rst = 1'b0;   // pointer back to 0
        req = 4'b1111; req_addr = 8'b11_10_01_00;
        for (int k = 0; k < 5; k++) begin
`ifdef ROM_ARB_RR_EN
            w = k % 4;
`else
            w = 0;
`endif
            exp_gnt  = 4'b0001 << w;
            exp_data = rom_mem[w];
            step();
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected 1", k, busy); end
            if (k == 4) req = 4'b0000;
            step();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b expected 1", k, rsp_valid); end
            checks++; if (rsp_id !== w[1:0]) begin errors++; $display("FAIL b2b_rsp_id[%0d]: got %0d expected %0d", k, rsp_id, w); end
            checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL b2b_rsp_data[%0d]: got %b expected %b", k, rsp_data, exp_data); end
        end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b expected 0", busy); end
    endtask

    // After reset both builds grant 0 first; dropping req[0] hands over to 1.
    task automatic test_drop_req0();
        rst = 1'b1; #2; rst = 1'b0;
        req = 4'b1111; req_addr = 8'b11_10_01_00;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop0_gnt0: got %b expected 0001", gnt); end
        req = 4'b1110;
        step();
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL drop0_rsp_id0: got %0d expected 0", rsp_id); end
        checks++; if (rsp_data !== 4'b0001) begin errors++; $display("FAIL drop0_rsp_data0: got %b expected 0001", rsp_data); end
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop0_gnt1: got %b expected 0010", gnt); end
        req = 4'b0000;
        step();
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL drop0_rsp_id1: got %0d expected 1", rsp_id); end
        checks++; if (rsp_data !== 4'b0010) begin errors++; $display("FAIL drop0_rsp_data1: got %b expected 0010", rsp_data); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop0_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_issue();
        req = 4'b0100; req_addr = 8'b11_10_01_00;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rstmid_gnt_before: got %b expected 0100", gnt); end
        req = 4'b1010;
        #2 rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt_async: got %b expected 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async: got %b expected 0", busy); end
        checks++; if (rom_addr !== 2'b00) begin errors++; $display("FAIL rstmid_rom_addr_async: got %b expected 00", rom_addr); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp: got %b expected 0", rsp_valid); end
        rst = 1'b0;
        step();
        // Pointer restarted at 0, so requester 1 beats requester 3 in either build.
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_regrant: got %b expected 0010", gnt); end
        req = 4'b0000;
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_data !== 4'b0010) begin errors++; $display("FAIL rstmid_rsp_data: got %b expected 0010", rsp_data); end
        step();
    endtask

    task automatic test_withdraw();
        // rom_addr is 01 from the previous read.
        req = 4'b1000; req_addr = 8'b11_00_00_00;
        #2 req = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 2'b01) begin
                errors++;
                $display("FAIL withdraw[%0d]: got gnt=%b rsp_valid=%b busy=%b rom_addr=%b expected 0000 0 0 01",
                         k, gnt, rsp_valid, busy, rom_addr);
            end
        end
    endtask

    task automatic test_addr_change();
        req = 4'b0010; req_addr = 8'b00_00_01_00;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL addrchg_gnt: got %b expected 0010", gnt); end
        req = 4'b0000; req_addr = 8'b00_00_11_00;
        step();
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL addrchg_rsp_id: got %0d expected 1", rsp_id); end
        checks++; if (rsp_data !== 4'b0010) begin errors++; $display("FAIL addrchg_rsp_data: got %b expected 0010", rsp_data); end
        step();
        checks++; if (rom_addr !== 2'b01) begin errors++; $display("FAIL addrchg_rom_addr: got %b expected 01", rom_addr); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_drop_req0();
        test_reset_mid_issue();
        test_withdraw();
        test_addr_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
